id_decode_stage: RTL and testbench
==================================

// Module: id_decode_stage
// PURPOSE
//  Registered RV32I instruction-decode stage for the 32I core. Decodes one instruction per cycle into an ID/EX control bundle.
//  - Bundle: ALU op, memory size/sign, writeback select, jump kind, register indices, sign-extended immediate, illegal flag.
//  - Sits between the IF buffer and EX, with valid/ready handshakes on both sides.
//  - Adds a load-use interlock and a branch flush; optional M-extension MUL.
// PARAMETERS
//  XLEN           32  datapath width of pc and imm
//  ENABLE_M       0   1: decode MUL (f7=0000001, f3=000); all other M encodings are illegal
//  LOAD_USE_DEPTH 1   issued slots (out reg + shadow) whose load rd blocks a consumer; range 1..3
// PORTS
//  clk          in   1     rising-edge clock
//  reset        in   1     asynchronous, active-high
//  in_valid     in   1     IF presents in_inst/in_pc
//  in_ready     out  1     stage accepts this cycle
//  in_inst      in   32    instruction word
//  in_pc        in   XLEN  instruction address
//  flush        in   1     EX branch/jump redirect: kill held and incoming instruction
//  out_valid    out  1     bundle valid
//  out_ready    in   1     EX accepts bundle
//  out_pc       out  XLEN  pc of held instruction
//  out_rs1/rs2/rd out 5    register indices
//  out_imm      out  XLEN  sign-extended I/S/B/U/J immediate (0 for R-type)
//  out_alu_op   out  4     ADD0 SUB1 MUL2 AND3 OR4 XOR5 SHL6 SHR7 SLT8 SLTU9 AUIPC10 SRA11 PASSB12
//  out_alu_src  out  1     1: operand B = imm
//  out_mem_read/out_mem_write/out_reg_write out 1 each
//  out_mem_to_reg out 2    00 alu, 01 mem, 10 pc+4
//  out_jump     out  2     00 none, 01 branch, 10 jal, 11 jalr
//  out_inst_size out 2     00 byte, 01 half, 10 word
//  out_mem_unsigned out 1  lbu/lhu
//  out_illegal  out  1     unknown opcode/funct; reg_write=mem_read=mem_write=0, jump=00
// BEHAVIOUR
//  - Reset (async): out_valid=0, shadow entries invalid, all out_* bundle fields 0; in_ready follows its equation.
//  - Latency 1: instruction accepted at edge N appears with out_valid=1 after edge N.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - in_ready = (!out_valid | out_ready) & !hazard & !flush.
//  - Hold rule: while out_valid & !out_ready, every out_* field is stable.
//  - Decode: lui->PASSB; auipc->AUIPC; load/store/addi->ADD; branches->SUB, jump=01.
//  - srl/srli->SHR; sra/srai->SRA; jal/jalr->ADD, mem_to_reg=10.
//  - alu_src=1 for op-imm, load, store, lui, auipc, jal, jalr.
//  - Shift-immediates with bad f7 are illegal; reserved load/store f3 are illegal.
//  - rd forced 0 for store and branch. Writes to x0 keep reg_write=1; the regfile ignores them.
//  - Hazard: incoming rs1 (and rs2 if the format reads rs2) equals a nonzero rd of a valid load in any of LOAD_USE_DEPTH slots.
//    - Slot0 = out register; slots 1.. = shadow.
//    - Shadow shifts on each out_fire (slot0 content enters slot1).
//    - Stalled instruction waits in IF; in_ready=0.
//  - Flush: at edge with flush=1, out_valid<=0 and all shadow entries invalid; incoming instruction not captured.
//    - Flush beats capture and out_ready.
//  - Simultaneous out_fire and in_fire: new bundle replaces old the same edge.
//  - Empty register and !hazard: in_ready=1 regardless of out_ready.
//  - Reset mid-transfer: bundle discarded; no partial state survives.
// STRUCTURE
//  - Shared package riscv_ctrl_pkg: opcode constants, ALU_*, BYTE/HALF/WORD, WB_*, JMP_* localparams.
//  - Package also holds the ctrl bundle struct/width.
//  - Sub-module rv_imm_gen (combinational: inst -> imm, format select).
//  - Decode logic, out register, shadow scoreboard and handshake stay in this module.
// TESTING
//  - addi x1,x0,5 (0x00500093): out_valid next cycle; alu_op=0, alu_src=1, reg_write=1, rd=1, imm=5.
//  - lw x2,0(x1) (0x0000A103) then add x3,x2,x2 (0x002101B3), out_ready=1, depth 1: in_ready=0 for exactly 1 cycle.
//    - add issues one cycle later; with depth 2 the stall is 2 cycles.
//  - jal x1,8 (0x008000EF): jump=10, mem_to_reg=10, imm=8, rd=1. 0xFFFFFFFF: illegal=1, reg_write=0.
//  - mul x3,x1,x2 (0x022081B3): ENABLE_M=0 -> illegal=1; ENABLE_M=1 -> alu_op=2.
//  - out_ready=0 for 3 cycles with bundle held: all outputs stable, in_ready=0; then flush=1 -> out_valid=0 next edge.
//  - Async reset asserted mid-stall (between edges): out_valid drops immediately, in_ready=1 after release.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared RV32I decode constants and ID/EX control bundle
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_MUL   = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_OR    = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SHL   = 4'd6;
  localparam logic [3:0] ALU_SHR   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_AUIPC = 4'd10;
  localparam logic [3:0] ALU_SRA   = 4'd11;
  localparam logic [3:0] ALU_PASSB = 4'd12;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_BR   = 2'b01;
  localparam logic [1:0] JMP_JAL  = 2'b10;
  localparam logic [1:0] JMP_JALR = 2'b11;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] jump;
    logic [1:0] inst_size;
    logic       mem_unsigned;
    logic       illegal;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - combinational RV32I immediate extractor
// Ports:
//   inst  in  inst[31:7] (opcode bits are not needed here)
//   fmt   in  immediate format (imm_fmt_e)
//   imm   out sign-extended immediate, 0 for IMM_NONE
module rv_imm_gen
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - registered RV32I decode stage with load-use interlock and flush
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_inst/in_pc   IF side handshake
//   flush                              EX redirect, kills held and incoming instruction
//   out_valid/out_ready                EX side handshake
//   out_pc, out_rs1/rs2/rd, out_imm    operands of the held instruction
//   out_alu_op, out_alu_src, out_mem_read, out_mem_write, out_reg_write,
//   out_mem_to_reg, out_jump, out_inst_size, out_mem_unsigned, out_illegal  control bundle
module id_decode_stage
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ENABLE_M       = 0,
  parameter int LOAD_USE_DEPTH = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_src,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_reg_write,
  output logic [1:0]      out_mem_to_reg,
  output logic [1:0]      out_jump,
  output logic [1:0]      out_inst_size,
  output logic            out_mem_unsigned,
  output logic            out_illegal
);

  // Shadow holds slots 1..LOAD_USE_DEPTH-1; one dummy entry when depth is 1.
  localparam int SH_N = (LOAD_USE_DEPTH > 1) ? LOAD_USE_DEPTH - 1 : 1;

  ctrl_t           dec;
  ctrl_t           ctrl_q;
  imm_fmt_e        fmt;
  logic            reads_rs2;
  logic            bad;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] pc_q;
  logic            hazard;
  logic            slot0_load;
  logic            advance;
  logic            in_fire;
  logic            out_fire;
  logic [SH_N-1:0]       sh_v;
  logic [SH_N-1:0][4:0]  sh_rd;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (in_inst[31:7]),
    .fmt  (fmt),
    .imm  (imm)
  );

  always_comb begin
    dec       = '0;
    fmt       = IMM_NONE;
    reads_rs2 = 1'b0;
    bad       = 1'b0;
    dec.rs1   = in_inst[19:15];
    dec.rs2   = in_inst[24:20];
    dec.rd    = in_inst[11:7];
    case (opc)
      OPC_LUI: begin
        fmt = IMM_U; dec.alu_op = ALU_PASSB; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        fmt = IMM_U; dec.alu_op = ALU_AUIPC; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        fmt = IMM_J; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        dec.mem_to_reg = WB_PC4; dec.jump = JMP_JAL;
      end
      OPC_JALR: begin
        fmt = IMM_I; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        dec.mem_to_reg = WB_PC4; dec.jump = JMP_JALR;
        bad = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        fmt = IMM_B; dec.alu_op = ALU_SUB; dec.jump = JMP_BR; dec.rd = 5'd0;
        reads_rs2 = 1'b1;
        bad = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        fmt = IMM_I; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
        dec.reg_write = 1'b1; dec.mem_to_reg = WB_MEM;
        dec.inst_size = f3[1:0]; dec.mem_unsigned = f3[2];
        // legal f3: 000 001 010 100 101
        bad = (f3[1:0] == 2'b11) | (f3[2] & f3[1]);
      end
      OPC_STORE: begin
        fmt = IMM_S; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
        dec.rd = 5'd0; dec.inst_size = f3[1:0]; reads_rs2 = 1'b1;
        bad = f3[2] | (f3[1:0] == 2'b11);
      end
      OPC_OPIMM: begin
        fmt = IMM_I; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op = ALU_SHL;
            bad = (f7 != 7'b0000000);
          end
          default: begin
            if (f7 == 7'b0000000)      dec.alu_op = ALU_SHR;
            else if (f7 == 7'b0100000) dec.alu_op = ALU_SRA;
            else                       bad = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.reg_write = 1'b1; reads_rs2 = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.alu_op = ALU_ADD;
            3'b001:  dec.alu_op = ALU_SHL;
            3'b010:  dec.alu_op = ALU_SLT;
            3'b011:  dec.alu_op = ALU_SLTU;
            3'b100:  dec.alu_op = ALU_XOR;
            3'b101:  dec.alu_op = ALU_SHR;
            3'b110:  dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
        end else if (ENABLE_M != 0 && f7 == 7'b0000001 && f3 == 3'b000) begin
          dec.alu_op = ALU_MUL;
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    // An illegal instruction must have no architectural side effect downstream.
    if (bad) begin
      dec.illegal   = 1'b1;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.jump      = JMP_NONE;
    end
  end

  // Slot 0 is the out register itself; it only counts while it holds a real load.
  assign slot0_load = out_valid & ctrl_q.mem_read & (ctrl_q.rd != 5'd0);

  always_comb begin
    hazard = slot0_load & ((dec.rs1 == ctrl_q.rd) | (reads_rs2 & (dec.rs2 == ctrl_q.rd)));
    for (int k = 0; k < SH_N; k++) begin
      if (LOAD_USE_DEPTH > 1 && sh_v[k] &&
          ((dec.rs1 == sh_rd[k]) | (reads_rs2 & (dec.rs2 == sh_rd[k]))))
        hazard = 1'b1;
    end
  end

  // The out slot moves forward whenever it is empty or being consumed; an empty
  // slot moving forward ages the shadow with a bubble so a stall cannot wedge.
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance & !hazard & !flush;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      ctrl_q    <= dec;
      imm_q     <= imm;
      pc_q      <= in_pc;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_v  <= '0;
      sh_rd <= '0;
    end else if (flush) begin
      sh_v  <= '0;
    end else if (advance) begin
      for (int k = SH_N - 1; k > 0; k--) begin
        sh_v[k]  <= sh_v[k-1];
        sh_rd[k] <= sh_rd[k-1];
      end
      sh_v[0]  <= slot0_load;
      sh_rd[0] <= ctrl_q.rd;
    end
  end

  assign out_pc           = pc_q;
  assign out_imm          = imm_q;
  assign out_rs1          = ctrl_q.rs1;
  assign out_rs2          = ctrl_q.rs2;
  assign out_rd           = ctrl_q.rd;
  assign out_alu_op       = ctrl_q.alu_op;
  assign out_alu_src      = ctrl_q.alu_src;
  assign out_mem_read     = ctrl_q.mem_read;
  assign out_mem_write    = ctrl_q.mem_write;
  assign out_reg_write    = ctrl_q.reg_write;
  assign out_mem_to_reg   = ctrl_q.mem_to_reg;
  assign out_jump         = ctrl_q.jump;
  assign out_inst_size    = ctrl_q.inst_size;
  assign out_mem_unsigned = ctrl_q.mem_unsigned;
  assign out_illegal      = ctrl_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - directed self-checking bench for id_decode_stage
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;

  always #5 clk = ~clk;

  logic a_in_ready, a_out_valid, a_out_alu_src, a_out_mem_read, a_out_mem_write, a_out_reg_write;
  logic a_out_mem_unsigned, a_out_illegal;
  logic [31:0] a_out_pc, a_out_imm;
  logic [4:0] a_out_rs1, a_out_rs2, a_out_rd;
  logic [3:0] a_out_alu_op;
  logic [1:0] a_out_mem_to_reg, a_out_jump, a_out_inst_size;

  logic b_in_ready, b_out_valid, b_out_alu_src, b_out_mem_read, b_out_mem_write, b_out_reg_write;
  logic b_out_mem_unsigned, b_out_illegal;
  logic [31:0] b_out_pc, b_out_imm;
  logic [4:0] b_out_rs1, b_out_rs2, b_out_rd;
  logic [3:0] b_out_alu_op;
  logic [1:0] b_out_mem_to_reg, b_out_jump, b_out_inst_size;

  id_decode_stage #(.XLEN(32), .ENABLE_M(0), .LOAD_USE_DEPTH(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_rd(a_out_rd), .out_imm(a_out_imm),
    .out_alu_op(a_out_alu_op), .out_alu_src(a_out_alu_src), .out_mem_read(a_out_mem_read),
    .out_mem_write(a_out_mem_write), .out_reg_write(a_out_reg_write),
    .out_mem_to_reg(a_out_mem_to_reg), .out_jump(a_out_jump), .out_inst_size(a_out_inst_size),
    .out_mem_unsigned(a_out_mem_unsigned), .out_illegal(a_out_illegal)
  );

  id_decode_stage #(.XLEN(32), .ENABLE_M(1), .LOAD_USE_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd), .out_imm(b_out_imm),
    .out_alu_op(b_out_alu_op), .out_alu_src(b_out_alu_src), .out_mem_read(b_out_mem_read),
    .out_mem_write(b_out_mem_write), .out_reg_write(b_out_reg_write),
    .out_mem_to_reg(b_out_mem_to_reg), .out_jump(b_out_jump), .out_inst_size(b_out_inst_size),
    .out_mem_unsigned(b_out_mem_unsigned), .out_illegal(b_out_illegal)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADDI5  = 32'h00500093;
  localparam logic [31:0] I_ADDIM1 = 32'hFFF00093;
  localparam logic [31:0] I_ADDI7  = 32'h00700113;
  localparam logic [31:0] I_LW     = 32'h0000A103;
  localparam logic [31:0] I_ADD    = 32'h002101B3;
  localparam logic [31:0] I_JAL    = 32'h008000EF;
  localparam logic [31:0] I_BAD    = 32'hFFFFFFFF;
  localparam logic [31:0] I_SRAI   = 32'h40335293;
  localparam logic [31:0] I_SRLBAD = 32'h20335293;
  localparam logic [31:0] I_SW     = 32'h0020A423;
  localparam logic [31:0] I_MUL    = 32'h022081B3;

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 32'h0;
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", a_out_valid); end
    checks++; if (a_out_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h want 0", a_out_imm); end
    checks++; if (a_out_alu_op !== 4'd0 || a_out_rd !== 5'd0 || a_out_reg_write !== 1'b0) begin
      errors++; $display("FAIL reset_bundle got op=%0d rd=%0d rw=%0b want 0 0 0", a_out_alu_op, a_out_rd, a_out_reg_write); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", a_in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    do_reset();
    in_valid = 1'b1; in_inst = I_ADDI5; in_pc = 32'h100;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready got %0b want 1", a_in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", a_out_valid); end
    checks++; if (a_out_alu_op !== 4'd0 || a_out_alu_src !== 1'b1 || a_out_reg_write !== 1'b1) begin
      errors++; $display("FAIL addi_ctrl got op=%0d src=%0b rw=%0b want 0 1 1", a_out_alu_op, a_out_alu_src, a_out_reg_write); end
    checks++; if (a_out_rd !== 5'd1 || a_out_imm !== 32'd5 || a_out_pc !== 32'h100) begin
      errors++; $display("FAIL addi_fields got rd=%0d imm=%h pc=%h want 1 5 100", a_out_rd, a_out_imm, a_out_pc); end
    issue(I_ADDIM1, 32'h104);
    checks++; if (a_out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_neg_imm got %h want ffffffff", a_out_imm); end
  endtask

  task automatic test_decode();
    do_reset();
    issue(I_JAL, 32'h10);
    checks++; if (a_out_jump !== 2'b10 || a_out_mem_to_reg !== 2'b10 || a_out_imm !== 32'd8 || a_out_rd !== 5'd1) begin
      errors++; $display("FAIL jal got jump=%0d wb=%0d imm=%h rd=%0d want 2 2 8 1", a_out_jump, a_out_mem_to_reg, a_out_imm, a_out_rd); end
    issue(I_BAD, 32'h14);
    checks++; if (a_out_illegal !== 1'b1 || a_out_reg_write !== 1'b0 || a_out_jump !== 2'b00) begin
      errors++; $display("FAIL illegal_ones got ill=%0b rw=%0b jump=%0d want 1 0 0", a_out_illegal, a_out_reg_write, a_out_jump); end
    issue(I_SRAI, 32'h18);
    checks++; if (a_out_alu_op !== 4'd11 || a_out_illegal !== 1'b0 || a_out_rd !== 5'd5) begin
      errors++; $display("FAIL srai got op=%0d ill=%0b rd=%0d want 11 0 5", a_out_alu_op, a_out_illegal, a_out_rd); end
    issue(I_SRLBAD, 32'h1C);
    checks++; if (a_out_illegal !== 1'b1 || a_out_reg_write !== 1'b0) begin
      errors++; $display("FAIL shift_bad_f7 got ill=%0b rw=%0b want 1 0", a_out_illegal, a_out_reg_write); end
    issue(I_SW, 32'h20);
    checks++; if (a_out_rd !== 5'd0 || a_out_mem_write !== 1'b1 || a_out_imm !== 32'd8 || a_out_reg_write !== 1'b0 || a_out_inst_size !== 2'b10) begin
      errors++; $display("FAIL sw got rd=%0d mw=%0b imm=%h rw=%0b sz=%0d want 0 1 8 0 2", a_out_rd, a_out_mem_write, a_out_imm, a_out_reg_write, a_out_inst_size); end
    issue(I_MUL, 32'h24);
    checks++; if (a_out_illegal !== 1'b1) begin errors++; $display("FAIL mul_no_m got ill=%0b want 1", a_out_illegal); end
    checks++; if (b_out_alu_op !== 4'd2 || b_out_illegal !== 1'b0) begin
      errors++; $display("FAIL mul_m got op=%0d ill=%0b want 2 0", b_out_alu_op, b_out_illegal); end
  endtask

  task automatic test_load_use();
    int first_a;
    int first_b;
    do_reset();
    issue(I_LW, 32'h40);
    checks++; if (a_out_mem_read !== 1'b1 || a_out_rd !== 5'd2 || a_out_inst_size !== 2'b10 || a_out_mem_to_reg !== 2'b01) begin
      errors++; $display("FAIL lw got mr=%0b rd=%0d sz=%0d wb=%0d want 1 2 2 1", a_out_mem_read, a_out_rd, a_out_inst_size, a_out_mem_to_reg); end
    in_valid = 1'b1; in_inst = I_ADD; in_pc = 32'h44;
    first_a = -1; first_b = -1;
    #1;
    for (int c = 1; c <= 6; c++) begin
      if (a_in_ready === 1'b1 && first_a < 0) first_a = c;
      if (b_in_ready === 1'b1 && first_b < 0) first_b = c;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    checks++; if (first_a != 2) begin errors++; $display("FAIL stall_depth1 got first_ready_cycle=%0d want 2", first_a); end
    checks++; if (first_b != 3) begin errors++; $display("FAIL stall_depth2 got first_ready_cycle=%0d want 3", first_b); end
    checks++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd3 || a_out_rs1 !== 5'd2 || a_out_rs2 !== 5'd2 || a_out_alu_op !== 4'd0) begin
      errors++; $display("FAIL add_issue got v=%0b rd=%0d rs1=%0d rs2=%0d op=%0d want 1 3 2 2 0", a_out_valid, a_out_rd, a_out_rs1, a_out_rs2, a_out_alu_op); end
    checks++; if (b_out_rd !== 5'd3) begin errors++; $display("FAIL add_issue_depth2 got rd=%0d want 3", b_out_rd); end
  endtask

  task automatic test_hold_flush();
    do_reset();
    out_ready = 1'b0;
    issue(I_ADDI5, 32'h200);
    in_valid = 1'b1; in_inst = I_JAL; in_pc = 32'h204;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (a_out_valid !== 1'b1 || a_out_imm !== 32'd5 || a_out_rd !== 5'd1 || a_out_pc !== 32'h200 || a_out_jump !== 2'b00) begin
        errors++; $display("FAIL hold_stable cyc=%0d got v=%0b imm=%h rd=%0d pc=%h jump=%0d want 1 5 1 200 0", c, a_out_valid, a_out_imm, a_out_rd, a_out_pc, a_out_jump); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc=%0d got %0b want 0", c, a_in_ready); end
      @(posedge clk); #2;
    end
    flush = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b want 0", a_in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", a_out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    issue(I_LW, 32'h300);
    in_valid = 1'b1; in_inst = I_ADD; in_pc = 32'h304;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL stall_before_reset got %0b want 0", a_in_ready); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %0b want 0", a_out_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b1 || a_out_rd !== 5'd0 || a_out_mem_read !== 1'b0) begin
      errors++; $display("FAIL after_reset got rdy=%0b rd=%0d mr=%0b want 1 0 0", a_in_ready, a_out_rd, a_out_mem_read); end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_inst = I_ADDI5; in_pc = 32'h400;
    @(posedge clk); #1;
    checks++; if (a_out_rd !== 5'd1 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first got rd=%0d rdy=%0b want 1 1", a_out_rd, a_in_ready); end
    in_inst = I_ADDI7; in_pc = 32'h404;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd2 || a_out_imm !== 32'd7 || a_out_pc !== 32'h404) begin
      errors++; $display("FAIL b2b_second got v=%0b rd=%0d imm=%h pc=%h want 1 2 7 404", a_out_valid, a_out_rd, a_out_imm, a_out_pc); end
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_decode();
    test_load_use();
    test_hold_flush();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
